// File: rtl/wts_pkg.sv
// Shared types and constants for the wavetable envelope generator.
// Level is 7 bits (0..127); rates are 4 bits where 0 freezes a phase.
package wts_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } wts_state_e;

  localparam int LEVEL_W    = 7;
  localparam int RATE_W     = 4;
  localparam int BYPASS_BIT = 7;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 7'd127;
  localparam logic [RATE_W-1:0]  RATE_MAX  = 4'd15;

  // Sustain select maps onto the top four level bits: 0, 8, ... 120.
  function automatic logic [LEVEL_W-1:0] sustain_target(input logic [RATE_W-1:0] sl);
    return {sl, 3'b000};
  endfunction

endpackage

// File: rtl/wts_envelope_generator_if.sv
// Control/register/result bundle between the voice sequencer and the envelope generator.
interface wts_envelope_generator_if;
  import wts_pkg::*;

  logic                tick;
  logic                key_on;
  logic                key_off;
  logic [RATE_W-1:0]   reg_ar;
  logic [RATE_W-1:0]   reg_dr;
  logic [RATE_W-1:0]   reg_rr;
  logic [RATE_W-1:0]   reg_sl;
  logic                reg_env_enable;
  logic [7:0]          envelope;
  logic                active;

  modport master (
    output tick, key_on, key_off,
    output reg_ar, reg_dr, reg_rr, reg_sl, reg_env_enable,
    input  envelope, active
  );

  modport slave (
    input  tick, key_on, key_off,
    input  reg_ar, reg_dr, reg_rr, reg_sl, reg_env_enable,
    output envelope, active
  );

endinterface

// File: rtl/wts_env_rate_divider.sv
// Tick prescaler: a step fires on the tick that finds the counter at or above 15 - rate.
// Rate 0 holds the counter and never steps; clear wins over any coincident tick.
module wts_env_rate_divider
  import wts_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              clear,
  input  logic [RATE_W-1:0] rate,
  output logic              step
);

  logic [RATE_W-1:0] cnt;
  logic [RATE_W-1:0] limit;
  logic              live;
  logic              terminal;

  assign limit    = RATE_MAX - rate;
  assign live     = tick && !clear && (rate != '0);
  // ">=" rather than "==" so a rate raised mid-count still steps on the next tick.
  assign terminal = (cnt >= limit);
  assign step     = live && terminal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (live) begin
      cnt <= terminal ? '0 : cnt + RATE_W'(1);
    end
  end

endmodule

// File: rtl/wts_envelope_generator.sv
// ADSR envelope generator: 7-bit level driven by per-phase rate dividers, bypass flag in bit 7.
//   state      | meaning
//   ST_IDLE    | no note, level 0, active low
//   ST_ATTACK  | level rises toward 127 at reg_ar
//   ST_DECAY   | level falls toward {reg_sl,000} at reg_dr
//   ST_SUSTAIN | level held, ticks ignored
//   ST_RELEASE | level falls toward 0 at reg_rr
module wts_envelope_generator
  import wts_pkg::*;
(
  input logic                    clk,
  input logic                    reset,
  wts_envelope_generator_if.slave bus
);

  wts_state_e         state, state_nxt;
  logic [LEVEL_W-1:0] level, level_nxt;
  logic [LEVEL_W-1:0] target;
  logic [RATE_W-1:0]  rate_sel;
  logic               clear;
  logic               step;
  logic               release_ok;
  logic [7:0]         env_q;
  logic               active_q;

  assign target     = sustain_target(bus.reg_sl);
  assign release_ok = (state == ST_ATTACK) || (state == ST_DECAY) || (state == ST_SUSTAIN);
  assign clear      = bus.key_on || (bus.key_off && release_ok);

  always_comb begin
    rate_sel = '0;
    case (state)
      ST_ATTACK:  rate_sel = bus.reg_ar;
      ST_DECAY:   rate_sel = bus.reg_dr;
      ST_RELEASE: rate_sel = bus.reg_rr;
      default:    rate_sel = '0;
    endcase
  end

  wts_env_rate_divider u_div (
    .clk   (clk),
    .reset (reset),
    .tick  (bus.tick),
    .clear (clear),
    .rate  (rate_sel),
    .step  (step)
  );

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    if (bus.key_on) begin
      state_nxt = ST_ATTACK;
      level_nxt = '0;
    end else if (bus.key_off && release_ok) begin
      state_nxt = ST_RELEASE;
    end else begin
      case (state)
        ST_ATTACK: begin
          if (step) begin
            if (level >= LEVEL_MAX - LEVEL_W'(1)) begin
              level_nxt = LEVEL_MAX;
              state_nxt = ST_DECAY;
            end else begin
              level_nxt = level + LEVEL_W'(1);
            end
          end
        end
        ST_DECAY: begin
          // Already at or under the sustain point: settle without waiting for a tick.
          if (level <= target) begin
            state_nxt = ST_SUSTAIN;
          end else if (step) begin
            level_nxt = level - LEVEL_W'(1);
            if (level - LEVEL_W'(1) == target) state_nxt = ST_SUSTAIN;
          end
        end
        ST_RELEASE: begin
          if (level == '0) begin
            state_nxt = ST_IDLE;
          end else if (step) begin
            level_nxt = level - LEVEL_W'(1);
            if (level == LEVEL_W'(1)) state_nxt = ST_IDLE;
          end
        end
        default: begin
          state_nxt = state;
          level_nxt = level;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      level    <= '0;
      env_q    <= 8'h00;
      active_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      level    <= level_nxt;
      env_q    <= {~bus.reg_env_enable, level};
      active_q <= (state_nxt != ST_IDLE);
    end
  end

  assign bus.envelope = env_q;
  assign bus.active   = active_q;

endmodule

// File: tb/tb_wts_envelope_generator.sv
// Self-checking bench for wts_envelope_generator: directed scenarios plus random traffic
// compared cycle by cycle against a phase/level reference model.
module tb_wts_envelope_generator;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  wts_envelope_generator_if bus ();

  wts_envelope_generator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
  int       m_ph, m_lvl, m_acc;
  logic [7:0] exp_env;
  logic       exp_act;

  function automatic int phase_rate(int ph);
    case (ph)
      1: return int'(bus.reg_ar);
      2: return int'(bus.reg_dr);
      4: return int'(bus.reg_rr);
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 0; m_lvl = 0; m_acc = 0;
  endtask

  task automatic model_update(input bit kon, input bit koff, input bit tk);
    int  rate, period, tgt;
    bit  stepped;
    rate    = phase_rate(m_ph);
    period  = 16 - rate;
    tgt     = int'(bus.reg_sl) * 8;
    stepped = 0;
    if (kon) begin
      m_ph = 1; m_lvl = 0; m_acc = 0;
      return;
    end
    if (koff && m_ph >= 1 && m_ph <= 3) begin
      m_ph = 4; m_acc = 0;
      return;
    end
    if (tk && rate != 0) begin
      if (m_acc + 1 >= period) begin
        stepped = 1; m_acc = 0;
      end else begin
        m_acc = m_acc + 1;
      end
    end
    case (m_ph)
      1: if (stepped) begin
           if (m_lvl < 127) m_lvl = m_lvl + 1;
           if (m_lvl == 127) m_ph = 2;
         end
      2: if (m_lvl <= tgt) m_ph = 3;
         else if (stepped) begin
           m_lvl = m_lvl - 1;
           if (m_lvl == tgt) m_ph = 3;
         end
      4: if (m_lvl == 0) m_ph = 0;
         else if (stepped) begin
           m_lvl = m_lvl - 1;
           if (m_lvl == 0) m_ph = 0;
         end
      default: ;
    endcase
  endtask

  task automatic cycle(input bit kon, input bit koff, input bit tk);
    bus.key_on  = kon;
    bus.key_off = koff;
    bus.tick    = tk;
    exp_env = {~bus.reg_env_enable, 7'(m_lvl)};
    model_update(kon, koff, tk);
    exp_act = (m_ph != 0);
    @(posedge clk); #1;
    bus.key_on  = 1'b0;
    bus.key_off = 1'b0;
    bus.tick    = 1'b0;
  endtask

  task automatic set_regs(input logic [3:0] ar, dr, rr, sl, input logic en);
    bus.reg_ar = ar; bus.reg_dr = dr; bus.reg_rr = rr; bus.reg_sl = sl;
    bus.reg_env_enable = en;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_regs(4'd15, 4'd15, 4'd15, 4'd8, 1'b1);
    bus.key_on = 1'b1; bus.tick = 1'b1;
    #2;
    checks++;
    if (bus.envelope !== 8'h00 || bus.active !== 1'b0) begin
      errors++;
      $display("FAIL reset_async env=%h act=%b want env=00 act=0", bus.envelope, bus.active);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.envelope !== 8'h00 || bus.active !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses_ignored env=%h act=%b want env=00 act=0", bus.envelope, bus.active);
    end
    bus.key_on = 1'b0; bus.tick = 1'b0; bus.key_off = 1'b0;
    reset = 1'b0;
    model_reset();
    cycle(0, 0, 0);
    checks++;
    if (bus.envelope !== 8'h00 || bus.active !== 1'b0) begin
      errors++;
      $display("FAIL reset_release env=%h act=%b want env=00 act=0", bus.envelope, bus.active);
    end
  endtask

  task automatic test_attack_decay_sustain();
    set_regs(4'd15, 4'd15, 4'd15, 4'd8, 1'b1);
    cycle(1, 0, 0);
    for (int i = 0; i < 128 + 63 + 10; i++) begin
      cycle(0, 0, 1);
      checks++;
      if (bus.envelope !== exp_env || bus.active !== exp_act) begin
        errors++;
        $display("FAIL ads_cycle%0d env=%h act=%b want env=%h act=%b", i, bus.envelope, bus.active, exp_env, exp_act);
      end
      if (i == 127) begin
        checks++;
        if (bus.envelope !== 8'h7F) begin
          errors++;
          $display("FAIL ads_peak env=%h want 7f", bus.envelope);
        end
      end
    end
    checks++;
    if (bus.envelope !== 8'h40 || bus.active !== 1'b1) begin
      errors++;
      $display("FAIL ads_sustain env=%h act=%b want env=40 act=1", bus.envelope, bus.active);
    end
  endtask

  task automatic test_release_to_idle();
    set_regs(4'd15, 4'd15, 4'd15, 4'd8, 1'b1);
    cycle(0, 1, 0);
    for (int i = 0; i < 64; i++) begin
      cycle(0, 0, 1);
      checks++;
      if (bus.envelope !== exp_env || bus.active !== exp_act) begin
        errors++;
        $display("FAIL rel_cycle%0d env=%h act=%b want env=%h act=%b", i, bus.envelope, bus.active, exp_env, exp_act);
      end
    end
    cycle(0, 0, 0);
    checks++;
    if (bus.envelope !== 8'h00 || bus.active !== 1'b0) begin
      errors++;
      $display("FAIL rel_idle env=%h act=%b want env=00 act=0", bus.envelope, bus.active);
    end
    cycle(0, 1, 1);
    cycle(0, 0, 0);
    checks++;
    if (bus.envelope !== 8'h00 || bus.active !== 1'b0) begin
      errors++;
      $display("FAIL idle_keyoff_ignored env=%h act=%b want env=00 act=0", bus.envelope, bus.active);
    end
  endtask

  task automatic test_on_off_same_clk();
    set_regs(4'd15, 4'd15, 4'd15, 4'd8, 1'b1);
    cycle(1, 0, 0);
    for (int i = 0; i < 200; i++) cycle(0, 0, 1);
    cycle(1, 1, 1);
    cycle(0, 0, 0);
    checks++;
    if (bus.envelope !== 8'h00 || bus.active !== 1'b1) begin
      errors++;
      $display("FAIL on_off_same env=%h act=%b want env=00 act=1", bus.envelope, bus.active);
    end
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    checks++;
    if (bus.envelope !== 8'h01) begin
      errors++;
      $display("FAIL on_off_attacking env=%h want 01", bus.envelope);
    end
  endtask

  task automatic test_attack_rate14();
    set_regs(4'd14, 4'd15, 4'd15, 4'd8, 1'b1);
    cycle(1, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 1);
    cycle(0, 0, 0);
    checks++;
    if (bus.envelope !== 8'h0A || bus.active !== 1'b1) begin
      errors++;
      $display("FAIL attack_ar14 env=%h act=%b want env=0a act=1", bus.envelope, bus.active);
    end
  endtask

  task automatic test_sl15();
    set_regs(4'd15, 4'd15, 4'd15, 4'd15, 1'b1);
    cycle(1, 0, 0);
    for (int i = 0; i < 127; i++) cycle(0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      cycle(0, 0, 1);
      checks++;
      if (bus.envelope !== exp_env) begin
        errors++;
        $display("FAIL sl15_step%0d env=%h want %h", i, bus.envelope, exp_env);
      end
    end
    for (int i = 0; i < 10; i++) cycle(0, 0, 1);
    checks++;
    if (bus.envelope !== 8'h78 || bus.active !== 1'b1) begin
      errors++;
      $display("FAIL sl15_sustain env=%h act=%b want env=78 act=1", bus.envelope, bus.active);
    end
  endtask

  task automatic test_bypass_and_reset_abort();
    set_regs(4'd15, 4'd15, 4'd12, 4'd8, 1'b1);
    cycle(1, 0, 0);
    for (int i = 0; i < 30; i++) cycle(0, 0, 1);
    bus.reg_env_enable = 1'b0;
    cycle(0, 0, 1);
    checks++;
    if (bus.envelope !== 8'h9E) begin
      errors++;
      $display("FAIL bypass_30 env=%h want 9e", bus.envelope);
    end
    for (int i = 0; i < 5; i++) cycle(0, 0, 1);
    checks++;
    if (bus.envelope !== 8'hA3) begin
      errors++;
      $display("FAIL bypass_advancing env=%h want a3", bus.envelope);
    end
    bus.reg_env_enable = 1'b1;
    cycle(0, 1, 0);
    for (int i = 0; i < 9; i++) cycle(0, 0, 1);
    checks++;
    if (bus.envelope !== exp_env || bus.active !== 1'b1) begin
      errors++;
      $display("FAIL release_midway env=%h act=%b want env=%h act=1", bus.envelope, bus.active, exp_env);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.envelope !== 8'h00 || bus.active !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release env=%h act=%b want env=00 act=0", bus.envelope, bus.active);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    cycle(0, 0, 1);
    checks++;
    if (bus.envelope !== 8'h00 || bus.active !== 1'b0) begin
      errors++;
      $display("FAIL after_abort env=%h act=%b want env=00 act=0", bus.envelope, bus.active);
    end
  endtask

  task automatic test_random();
    bit kon, koff, tk;
    set_regs(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
             4'($urandom_range(15)), 1'b1);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) == 0)
        set_regs(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
                 4'($urandom_range(15)), 1'($urandom_range(1)));
      kon  = ($urandom_range(199) == 0);
      koff = ($urandom_range(79) == 0);
      tk   = ($urandom_range(2) != 0);
      cycle(kon, koff, tk);
      checks++;
      if (bus.envelope !== exp_env || bus.active !== exp_act) begin
        errors++;
        $display("FAIL random_cycle%0d env=%h act=%b want env=%h act=%b", i, bus.envelope, bus.active, exp_env, exp_act);
      end
    end
  endtask

  initial begin
    bus.key_on = 1'b0; bus.key_off = 1'b0; bus.tick = 1'b0;
    model_reset();
    test_reset();
    test_attack_decay_sustain();
    test_release_to_idle();
    test_on_off_same_clk();
    test_attack_rate14();
    test_sl15();
    test_bypass_and_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wts_envelope_generator.md
WTS_ENVELOPE_GENERATOR -- requirements
Module: wts_envelope_generator

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single system clock, all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-003 The block SHALL have port tick, input, 1 bit: one-clk-wide envelope time-base enable.
REQ-004 The block SHALL have port key_on, input, 1 bit: one-clk-wide note start pulse.
REQ-005 The block SHALL have port key_off, input, 1 bit: one-clk-wide note release pulse.
REQ-006 The block SHALL have ports reg_ar, reg_dr, reg_rr, inputs, 4 bits each: attack, decay and release rates, where 0 means frozen and 15 means fastest.
REQ-007 The block SHALL have port reg_sl, input, 4 bits: sustain level select.
REQ-008 The block SHALL have port reg_env_enable, input, 1 bit: 1 applies the envelope, 0 bypasses it.
REQ-009 The block SHALL have port envelope, output, 8 bits: bit7 is the bypass flag and bits 6:0 are the level (0..127), feeding the channel volume stage.
REQ-010 The block SHALL have port active, output, 1 bit: 1 whenever the state is not IDLE.

Function
REQ-011 The block SHALL implement the states IDLE, ATTACK, DECAY, SUSTAIN and RELEASE, holding a 7-bit level and a 4-bit tick counter.
REQ-012 Step period SHALL be (16 - rate) ticks: each tick increments the counter, and when the counter equals 15 - rate a step occurs and the counter clears.
REQ-013 Rate 0 SHALL freeze the current phase: no step occurs and the state is held, though key_on and key_off are still accepted.
REQ-014 key_on in any state SHALL, on the next clk, set level to 0, clear the counter and enter ATTACK.
REQ-015 ATTACK step: level +1; the step that makes level 127 SHALL also enter DECAY and clear the counter.
REQ-016 Sustain target SHALL be {reg_sl, 3'b000}, giving a range of 0..120.
REQ-017 DECAY step: level -1 while level > target; the step reaching the target SHALL enter SUSTAIN.
REQ-018 If level <= target in DECAY, the block SHALL enter SUSTAIN on the next clk with no tick required and the level unchanged.
REQ-019 SUSTAIN SHALL hold the level indefinitely and ignore tick.
REQ-020 key_off in ATTACK, DECAY or SUSTAIN SHALL enter RELEASE on the next clk, keeping the current level and clearing the counter.
REQ-021 key_off in IDLE or RELEASE SHALL be ignored.
REQ-022 RELEASE step: level -1; the step reaching 0 SHALL enter IDLE.
REQ-023 RELEASE entered with level 0 SHALL go to IDLE on the next clk.
REQ-024 key_on and key_off asserted in the same clk: key_on SHALL win.
REQ-025 key_on coincident with tick: key_on SHALL win and that tick is discarded.
REQ-026 Level arithmetic SHALL never wrap: no increment above 127 and no decrement below 0.
REQ-027 envelope SHALL be registered as { ~reg_env_enable, level }, giving 1-clk latency from a state or level change.
REQ-028 The state machine SHALL keep running while reg_env_enable = 0; only bit7 of envelope reflects the bypass.
REQ-029 Register changes mid-phase SHALL take effect on the next tick comparison; the counter is not cleared by a register change.
REQ-030 If a counter value is already above the new 15 - rate, the next tick SHALL force a step and clear the counter.

Reset
REQ-031 While reset = 1, the block SHALL force state = IDLE, level = 0, counter = 0, envelope = 8'h00 and active = 0, asynchronously.
REQ-032 key_on, key_off and tick pulses SHALL be ignored while reset = 1.
REQ-033 Reset asserted mid-note SHALL abort to IDLE immediately, with no release phase.

Structure
REQ-034 The shared package wts_pkg SHALL hold the state encoding enum, the level width (7), the rate width (4), the level max constant (127) and the bypass bit index.
REQ-035 The block SHALL contain one sub-module, wts_env_rate_divider, holding the tick counter, the rate compare and a step pulse output, with a clear input.

Verification
REQ-036 Scenario: AR=15, DR=15, SL=8, tick every clk, key_on -> level 0..127 over 127 ticks, DECAY to 64 in 63 ticks, then SUSTAIN holding 64.
REQ-037 Scenario: AR=14 (period 2 ticks), key_on, 20 ticks -> level = 10 with state ATTACK.
REQ-038 Scenario: in SUSTAIN at 64, key_off with RR=15 -> level 0 after 64 ticks, then IDLE with active = 0 on that step's next clk.
REQ-039 Scenario: key_on and key_off in the same clk from SUSTAIN -> state ATTACK and level 0.
REQ-040 Scenario: SL=15 with level 127 entering DECAY -> 7 steps down to 120, then SUSTAIN.
REQ-041 Scenario: reg_env_enable=0 during ATTACK at level 30 -> envelope = 8'h9E while the level keeps advancing; reset asserted mid-RELEASE -> envelope = 8'h00 immediately and state IDLE.
